// File: rtl/mem_responder_if.sv
// Request/response bus between a multicycle core (master) and mem_responder (slave).
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        misaligned;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, busy, misaligned
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, busy, misaligned
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with a fixed number of wait states.
// Accepts one request in IDLE, optionally waits, then pulses ready for one cycle.
module mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 256
) (
    input logic           clk,
    input logic           rst,
    mem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           mis_q, mis_d;
    logic           we_q;
    logic [AW-1:0]  idx_q;
    logic [31:0]    wdata_q;
    logic [31:0]    rdata_q;

    logic           lat_en;
    logic           acc_en;
    logic           acc_we;
    logic [AW-1:0]  acc_idx;
    logic [31:0]    acc_wdata;
    logic [AW-1:0]  req_idx;

    logic [31:0]    mem_q [DEPTH];

    assign req_idx = bus.addr[AW+1:2];

    // Next-state and access control; with zero wait states the access uses the live bus fields.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mis_d     = mis_q;
        lat_en    = 1'b0;
        acc_en    = 1'b0;
        acc_we    = we_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    lat_en = 1'b1;
                    cnt_d  = 4'(WAIT_CYCLES);
                    if (bus.addr[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        acc_en    = 1'b1;
                        acc_we    = bus.we;
                        acc_idx   = req_idx;
                        acc_wdata = bus.wdata;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    acc_en  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                mis_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, request latches and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            if (lat_en) begin
                we_q    <= bus.we;
                idx_q   <= req_idx;
                wdata_q <= bus.wdata;
            end
            if (acc_en && !acc_we) begin
                rdata_q <= mem_q[acc_idx];
            end
        end
    end

    // Storage array, deliberately not reset; reset still blocks a pending write.
    always_ff @(posedge clk) begin
        if (!rst && acc_en && acc_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.ready      = (state_q == S_RESP);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two builds (2 and 0 wait states) against a word-level reference model.
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.WAIT_CYCLES(2), .DEPTH(256)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH(256)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: words keyed by sel*256 + word index, plus expected rdata per build.
    logic [31:0] mem_m [int unsigned];
    logic [31:0] rd_exp   [2];
    bit          rd_known [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus_a.req = r; bus_a.we = w; bus_a.addr = a; bus_a.wdata = d;
        end else begin
            bus_b.req = r; bus_b.we = w; bus_b.addr = a; bus_b.wdata = d;
        end
    endtask

    task automatic sample(input int sel, output logic rdy, output logic bsy,
                          output logic ms, output logic [31:0] rd);
        if (sel == 0) begin
            rdy = bus_a.ready; bsy = bus_a.busy; ms = bus_a.misaligned; rd = bus_a.rdata;
        end else begin
            rdy = bus_b.ready; bsy = bus_b.busy; ms = bus_b.misaligned; rd = bus_b.rdata;
        end
    endtask

    // Issue one request from an IDLE cycle, check the whole response window, end in the next IDLE cycle.
    task automatic issue(input int sel, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
        int          lat;
        bit          mis;
        int unsigned key;
        logic        rdy, bsy, ms;
        logic [31:0] rd;
        logic [31:0] old_exp;
        bit          old_known;
        mis       = (a[1:0] != 2'b00);
        lat       = mis ? 0 : ((sel == 0) ? 2 : 0);
        old_exp   = rd_exp[sel];
        old_known = rd_known[sel];
        drive(sel, 1'b1, w, a, d);
        @(posedge clk); #1;
        key = sel * 256 + ((a >> 2) % 256);
        if (!mis) begin
            if (w) begin
                mem_m[key] = d;
            end else if (mem_m.exists(key)) begin
                rd_exp[sel]   = mem_m[key];
                rd_known[sel] = 1'b1;
            end else begin
                rd_known[sel] = 1'b0;
            end
        end
        // Scramble the bus while busy; the responder must ignore all of it.
        drive(sel, hold, 1'($urandom), $urandom, $urandom);
        for (int k = 0; k <= lat + 1; k++) begin
            sample(sel, rdy, bsy, ms, rd);
            check($sformatf("s%0d a%h ready k%0d", sel, a, k), {31'b0, rdy}, {31'b0, (k == lat)});
            check($sformatf("s%0d a%h busy k%0d", sel, a, k), {31'b0, bsy}, {31'b0, (k <= lat)});
            check($sformatf("s%0d a%h misal k%0d", sel, a, k), {31'b0, ms}, {31'b0, (k == lat) && mis});
            if (k < lat) begin
                if (old_known) check($sformatf("s%0d a%h rdata_hold k%0d", sel, a, k), rd, old_exp);
            end else if (rd_known[sel]) begin
                check($sformatf("s%0d a%h rdata k%0d", sel, a, k), rd, rd_exp[sel]);
            end
            if (k <= lat) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        logic        rdy, bsy, ms;
        logic [31:0] rd;
        logic [31:0] r;
        logic [31:0] a;
        logic [1:0]  lo;

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s, rdy, bsy, ms, rd);
            check($sformatf("s%0d reset ready", s), {31'b0, rdy}, 32'd0);
            check($sformatf("s%0d reset busy", s), {31'b0, bsy}, 32'd0);
            check($sformatf("s%0d reset misal", s), {31'b0, ms}, 32'd0);
            check($sformatf("s%0d reset rdata", s), rd, 32'h0);
            rd_exp[s]   = 32'h0;
            rd_known[s] = 1'b1;
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); #1;

        // Basic write then read back.
        issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        // Misaligned read: flagged, no access, rdata held.
        issue(0, 1'b0, 32'h0000_0013, 32'h0, 1'b0);
        issue(0, 1'b1, 32'h0000_0013, 32'h1111_1111, 1'b0);
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        // Index wrap modulo DEPTH.
        issue(0, 1'b1, 32'h0000_0404, 32'h1234_5678, 1'b0);
        issue(0, 1'b0, 32'h0000_0004, 32'h0, 1'b0);

        // Reset during WAIT abandons a pending write.
        drive(0, 1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        sample(0, rdy, bsy, ms, rd);
        check("abort busy_before", {31'b0, bsy}, 32'd1);
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        rd_exp[0]   = 32'h0;
        rd_known[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample(0, rdy, bsy, ms, rd);
            check($sformatf("abort ready k%0d", k), {31'b0, rdy}, 32'd0);
            check($sformatf("abort busy k%0d", k), {31'b0, bsy}, 32'd0);
            check($sformatf("abort rdata k%0d", k), rd, 32'h0);
            @(posedge clk); #1;
        end
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);

        // Reset wins over a simultaneous request.
        drive(0, 1'b1, 1'b1, 32'h0000_0010, 32'h5555_5555);
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rd_exp[0] = 32'h0;
        sample(0, rdy, bsy, ms, rd);
        check("rst_req busy", {31'b0, bsy}, 32'd0);
        @(posedge clk); #1;
        sample(0, rdy, bsy, ms, rd);
        check("rst_req busy_after", {31'b0, bsy}, 32'd0);
        check("rst_req ready_after", {31'b0, rdy}, 32'd0);
        issue(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);

        // req held high continuously across back-to-back requests.
        issue(0, 1'b1, 32'h0000_0040, 32'hA0A0_0001, 1'b1);
        issue(0, 1'b1, 32'h0000_0080, 32'hB0B0_0002, 1'b1);
        issue(0, 1'b0, 32'h0000_0040, 32'h0, 1'b1);
        issue(0, 1'b0, 32'h0000_0080, 32'h0, 1'b1);
        issue(0, 1'b1, 32'h0000_0040, 32'hC0C0_0003, 1'b1);
        issue(0, 1'b0, 32'h0000_0040, 32'h0, 1'b1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Seed a small window so every random read has a known answer.
        for (int i = 0; i < 8; i++) begin
            issue(0, 1'b1, 32'(i * 4), $urandom, 1'($urandom_range(0, 1)));
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 30; i++) begin
            r  = $urandom;
            lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            a  = (r & 32'hFFFF_FC00) | 32'($urandom_range(0, 7) * 4) | {30'b0, lo};
            issue(0, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Zero-wait-state build.
        issue(1, 1'b1, 32'h0000_0008, 32'hA5A5_5A5A, 1'b0);
        issue(1, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
        issue(1, 1'b0, 32'h0000_1001, 32'h0, 1'b1);
        issue(1, 1'b1, 32'h0000_0408, 32'h0F0F_F0F0, 1'b1);
        issue(1, 1'b0, 32'h0000_0008, 32'h0, 1'b1);
        issue(1, 1'b1, 32'h0000_00FC, 32'h7777_8888, 1'b0);
        issue(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
